// File: rtl/imm_decode_stage.sv
// Immediate generator for the decode pipeline: builds I/S/B/U/J/Z immediates (plus CI/CJ when IMM_DECODE_RVC_EN is defined), sign/zero-extended to XLEN.
// Latency: 1 cycle (a beat accepted at edge N is presented on out_* during cycle N+1).
// Backpressure: output register + one skid register; in_ready = !skid_full, registered, so full throughput under stalls.
module imm_decode_stage #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_inst,
    input  logic [2:0]        in_sel,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_imm,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_err,
    output logic [7:0]        err_count
);

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [TAG_W-1:0] tag;
        logic             err;
    } beat_t;

    beat_t      out_q, out_d, skid_q, skid_d, new_beat;
    logic       out_valid_q, out_valid_d;
    logic       skid_full_q, skid_full_d;
    logic [7:0] err_count_q, err_count_d;
    logic [31:0] imm32;
    logic       sext;
    logic       illegal;
    logic       accept, drain;
    logic       unused_inst;

    // Opcode low bits select the format upstream; only some formats read them here.
    assign unused_inst = ^in_inst[6:0];

    always_comb begin
        imm32   = '0;
        sext    = 1'b1;
        illegal = 1'b0;
        case (in_sel)
            3'd0: imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
            3'd1: imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            3'd2: imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                           in_inst[11:8], 1'b0};
            3'd3: imm32 = {in_inst[31:12], 12'b0};
            3'd4: imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                           in_inst[30:21], 1'b0};
            3'd5: begin
                imm32 = {27'b0, in_inst[19:15]};
                sext  = 1'b0;
            end
`ifdef IMM_DECODE_RVC_EN
            3'd6: imm32 = {{26{in_inst[12]}}, in_inst[12], in_inst[6:2]};
            3'd7: imm32 = {{20{in_inst[12]}}, in_inst[12], in_inst[8], in_inst[10:9],
                           in_inst[6], in_inst[7], in_inst[2], in_inst[11],
                           in_inst[5:3], 1'b0};
`endif
            default: illegal = 1'b1;
        endcase
    end

    always_comb begin
        new_beat.tag = in_tag;
        new_beat.err = illegal;
        if (illegal) begin
            new_beat.imm = '0;
        end else if (sext) begin
            new_beat.imm = XLEN'($signed(imm32));
        end else begin
            new_beat.imm = XLEN'(imm32);
        end
    end

    assign accept = in_valid && in_ready;
    assign drain  = out_valid_q && out_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        out_d       = out_q;
        skid_full_d = skid_full_q;
        skid_d      = skid_q;
        err_count_d = err_count_q;
        if (skid_full_q) begin
            // in_ready is low here, so nothing new can arrive this cycle.
            if (drain) begin
                out_d       = skid_q;
                skid_full_d = 1'b0;
            end
        end else if (!out_valid_q || drain) begin
            out_valid_d = accept;
            if (accept) begin
                out_d = new_beat;
            end
        end else if (accept) begin
            skid_full_d = 1'b1;
            skid_d      = new_beat;
        end
        if (accept && illegal && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
            skid_full_q <= 1'b0;
            skid_q      <= '0;
            err_count_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            skid_full_q <= skid_full_d;
            skid_q      <= skid_d;
            err_count_q <= err_count_d;
        end
    end

    assign in_ready  = !skid_full_q;
    assign out_valid = out_valid_q;
    assign out_imm   = out_q.imm;
    assign out_tag   = out_q.tag;
    assign out_err   = out_q.err;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed bench for imm_decode_stage: formats, XLEN=64 extension, skid backpressure, illegal selects, async reset.
module tb_imm_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_inst = '0;
    logic [2:0]  in_sel = '0;
    logic [4:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_imm;
    logic [4:0]  out_tag;
    logic        out_err;
    logic [7:0]  err_count;

    logic        x_in_valid = 1'b0;
    logic        x_in_ready;
    logic [31:0] x_in_inst = '0;
    logic [2:0]  x_in_sel = '0;
    logic [4:0]  x_in_tag = '0;
    logic        x_out_valid;
    logic        x_out_ready = 1'b1;
    logic [63:0] x_out_imm;
    logic [4:0]  x_out_tag;
    logic        x_out_err;
    logic [7:0]  x_err_count;

    int n_checks = 0;
    int n_errors = 0;

    logic [4:0]  q_tag[$];
    logic [31:0] q_imm[$];
    int          sent;
    int          exp_cnt;

    always #5 clk = ~clk;

    imm_decode_stage #(.XLEN(32), .TAG_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
        .in_sel(in_sel), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
        .out_tag(out_tag), .out_err(out_err), .err_count(err_count)
    );

    imm_decode_stage #(.XLEN(64), .TAG_W(5)) dut64 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(x_in_valid), .in_ready(x_in_ready), .in_inst(x_in_inst),
        .in_sel(x_in_sel), .in_tag(x_in_tag),
        .out_valid(x_out_valid), .out_ready(x_out_ready), .out_imm(x_out_imm),
        .out_tag(x_out_tag), .out_err(x_out_err), .err_count(x_err_count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [31:0] inst, input logic [2:0] sel, input logic [4:0] tag);
        in_valid = 1'b1;
        in_inst  = inst;
        in_sel   = sel;
        in_tag   = tag;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [31:0] imm, input logic [4:0] t,
                              input logic err);
        check({tag, "_vld"}, 64'(out_valid), 64'd1);
        check({tag, "_imm"}, 64'(out_imm), 64'(imm));
        check({tag, "_tag"}, 64'(out_tag), 64'(t));
        check({tag, "_err"}, 64'(out_err), 64'(err));
    endtask

    initial begin
        // Reset state
        step();
        step();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_imm", 64'(out_imm), 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        check("rst_out_err", 64'(out_err), 64'd0);
        check("rst_err_count", 64'(err_count), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;

        // Basic formats, back to back with out_ready high
        drive(32'hFFF00093, 3'd0, 5'd1); step();
        expect_out("fmt_i_neg", 32'hFFFFFFFF, 5'd1, 1'b0);
        drive(32'h7FF00093, 3'd0, 5'd2); step();
        expect_out("fmt_i_pos", 32'h000007FF, 5'd2, 1'b0);
        drive(32'h00A12423, 3'd1, 5'd3); step();
        expect_out("fmt_s", 32'h00000008, 5'd3, 1'b0);
        drive(32'hFE000EE3, 3'd2, 5'd4); step();
        expect_out("fmt_b", 32'hFFFFFFFC, 5'd4, 1'b0);
        drive(32'h123450B7, 3'd3, 5'd5); step();
        expect_out("fmt_u", 32'h12345000, 5'd5, 1'b0);
        drive(32'h0010006F, 3'd4, 5'd6); step();
        expect_out("fmt_j", 32'h00000800, 5'd6, 1'b0);
        drive(32'h800F8073, 3'd5, 5'd7); step();
        expect_out("fmt_z", 32'h0000001F, 5'd7, 1'b0);
        in_valid = 1'b0; step();
        check("idle_out_valid", 64'(out_valid), 64'd0);

        // XLEN=64 extension
        x_in_valid = 1'b1; x_in_inst = 32'h800000B7; x_in_sel = 3'd3; x_in_tag = 5'd3;
        step();
        check("x64_u_imm", x_out_imm, 64'hFFFFFFFF80000000);
        check("x64_u_vld", 64'(x_out_valid), 64'd1);
        x_in_sel = 3'd5; x_in_tag = 5'd4;
        step();
        check("x64_z_imm", x_out_imm, 64'h0);
        check("x64_z_tag", 64'(x_out_tag), 64'd4);
        x_in_inst = 32'hFFF00093; x_in_sel = 3'd0;
        step();
        check("x64_i_imm", x_out_imm, 64'hFFFFFFFFFFFFFFFF);
        x_in_valid = 1'b0;

        // Backpressure through the skid register
        out_ready = 1'b0;
        drive(32'h00100093, 3'd0, 5'd1); step();
        check("bp1_in_ready", 64'(in_ready), 64'd1);
        expect_out("bp1", 32'h00000001, 5'd1, 1'b0);
        drive(32'h00200093, 3'd0, 5'd2); step();
        check("bp2_in_ready", 64'(in_ready), 64'd0);
        expect_out("bp2_hold", 32'h00000001, 5'd1, 1'b0);
        drive(32'h00300093, 3'd0, 5'd3); step();
        check("bp3_in_ready", 64'(in_ready), 64'd0);
        expect_out("bp3_hold", 32'h00000001, 5'd1, 1'b0);
        out_ready = 1'b1; step();
        expect_out("rel_2", 32'h00000002, 5'd2, 1'b0);
        check("rel_in_ready", 64'(in_ready), 64'd1);
        step();
        expect_out("rel_3", 32'h00000003, 5'd3, 1'b0);
        drive(32'h00400093, 3'd0, 5'd4); step();
        expect_out("rel_4", 32'h00000004, 5'd4, 1'b0);
        in_valid = 1'b0; step();
        check("rel_idle", 64'(out_valid), 64'd0);

        // Random valid/ready stream against a FIFO scoreboard
        sent = 0;
        @(negedge clk);
        for (int i = 0; i < 400; i++) begin
            out_ready = ($urandom_range(0, 1) == 1);
            in_valid  = (sent < 60) && ($urandom_range(0, 3) != 0);
            in_inst   = $urandom;
            in_sel    = 3'd0;
            in_tag    = 5'(sent);
            #1;
            if (out_valid && out_ready) begin
                if (q_tag.size() == 0) begin
                    check("sb_unexpected_beat", 64'(out_tag), 64'h1F);
                end else begin
                    check("sb_tag", 64'(out_tag), 64'(q_tag.pop_front()));
                    check("sb_imm", 64'(out_imm), 64'(q_imm.pop_front()));
                end
            end
            if (in_valid && in_ready) begin
                q_tag.push_back(in_tag);
                q_imm.push_back({{20{in_inst[31]}}, in_inst[31:20]});
                sent++;
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (out_valid) begin
                if (q_tag.size() == 0) begin
                    check("sb_unexpected_beat", 64'(out_tag), 64'h1F);
                end else begin
                    check("sb_tag", 64'(out_tag), 64'(q_tag.pop_front()));
                    check("sb_imm", 64'(out_imm), 64'(q_imm.pop_front()));
                end
            end
            @(negedge clk);
        end
        check("sb_all_sent", 64'(sent), 64'd60);
        check("sb_drained", 64'(q_tag.size()), 64'd0);
        step();

        // Selects 6/7
`ifdef IMM_DECODE_RVC_EN
        drive(32'hFFFFFFFF, 3'd6, 5'd9); step();
        expect_out("ci_ones", 32'hFFFFFFFF, 5'd9, 1'b0);
        drive(32'h000010FD, 3'd6, 5'd10); step();
        expect_out("ci_10fd", 32'hFFFFFFFF, 5'd10, 1'b0);
        drive(32'hFFFFFFFF, 3'd7, 5'd11); step();
        expect_out("cj_ones", 32'hFFFFFFFE, 5'd11, 1'b0);
        check("rvc_err_count", 64'(err_count), 64'd0);
`else
        drive(32'hFFFFFFFF, 3'd6, 5'd9); step();
        expect_out("ill6_a", 32'h0, 5'd9, 1'b1);
        check("ill_cnt1", 64'(err_count), 64'd1);
        drive(32'h000010FD, 3'd6, 5'd10); step();
        expect_out("ill6_b", 32'h0, 5'd10, 1'b1);
        check("ill_cnt2", 64'(err_count), 64'd2);
        drive(32'hFFFFFFFF, 3'd7, 5'd11); step();
        expect_out("ill7", 32'h0, 5'd11, 1'b1);
        check("ill_cnt3", 64'(err_count), 64'd3);
`endif
        for (int i = 0; i < 251; i++) step();
`ifdef IMM_DECODE_RVC_EN
        exp_cnt = 0;
`else
        exp_cnt = 254;
`endif
        check("cnt_254", 64'(err_count), 64'(exp_cnt));
        for (int i = 0; i < 46; i++) step();
        in_valid = 1'b0;
        step();
`ifdef IMM_DECODE_RVC_EN
        exp_cnt = 0;
`else
        exp_cnt = 255;
`endif
        check("cnt_sat", 64'(err_count), 64'(exp_cnt));

        // Asynchronous reset with both entries full
        out_ready = 1'b0;
        drive(32'h01500093, 3'd0, 5'd21); step();
        drive(32'h01600093, 3'd0, 5'd22); step();
        in_valid = 1'b0;
        check("full_in_ready", 64'(in_ready), 64'd0);
        check("full_out_valid", 64'(out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_in_ready", 64'(in_ready), 64'd1);
        check("arst_err_count", 64'(err_count), 64'd0);
        step();
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_rst_no_stale", 64'(out_valid), 64'd0);
        end
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        check("post_rst_err_count", 64'(err_count), 64'd0);
        drive(32'h12300093, 3'd0, 5'd5); step();
        expect_out("post_rst_beat", 32'h00000123, 5'd5, 1'b0);
        in_valid = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/imm_decode_stage.md
# imm_decode_stage

Registered, handshaked immediate-generation stage for the decode pipeline. It accepts one instruction word per cycle together with an immediate-format select and a passthrough tag, and emits the sign-extended immediate one cycle later. The output width is parameterised (XLEN 32 or 64), and the block adds a CSR zero-extended format plus illegal-select flagging. A two-entry skid buffer gives full throughput under downstream backpressure. The block sits between instruction fetch/decode and the register-read/execute boundary.

## Interface
- XLEN, 32, immediate output width; legal values 32 or 64.
- TAG_W, 5, width of the sideband tag carried alongside each beat.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  stage can accept a beat.
- in_inst  input  32  instruction word.
- in_sel  input  3  format select: 0=I, 1=S, 2=B, 3=U, 4=J, 5=Z (CSR zimm), 6 and 7 reserved (see Configuration).
- in_tag  input  TAG_W  sideband; returned unchanged.
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accepts the beat.
- out_imm  output  XLEN  generated immediate.
- out_tag  output  TAG_W  tag of the beat on out_imm.
- out_err  output  1  the beat on out_imm had an illegal select.
- err_count  output  8  saturating count of illegal-select beats accepted.

## Operation
- Immediates are assembled as 32-bit values first, then sign-extended to XLEN from bit 31. Z is the exception: it is zero-extended.
  - I: inst[31:20].
  - S: {inst[31:25], inst[11:7]}.
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - U: {inst[31:12], 12'b0}. With XLEN=64, U is also sign-extended.
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - Z: inst[19:15], zero-extended to XLEN.
- Illegal select: out_imm=0, out_err=1. The beat is still forwarded with its tag.
- err_count increments on each accepted illegal beat and holds at 255.
- Storage is an output register plus one skid register.
- An accepted beat goes to the output register if that register is empty or is draining this cycle. Otherwise it goes to the skid register.
- When the output drains and the skid register is full, the skid entry moves into the output register.
- in_ready = !skid_full (registered).
- Ordering is strictly FIFO. No beat is ever dropped or duplicated.
- Simultaneous accept and drain with the skid register empty: the new beat replaces the output. Throughput is 1 beat/cycle.

## Timing
- Latency: a beat accepted at edge N appears on out_* after edge N, i.e. it is valid during cycle N+1.
- Handshake rules:
  - A transfer occurs when valid && ready at a rising edge.
  - While out_valid=1 && out_ready=0, out_imm, out_tag and out_err hold stable.
  - in_ready does not depend combinationally on out_ready.
- Reset values: out_valid=0, out_imm=0, out_tag=0, out_err=0, err_count=0, skid register empty, in_ready=1.
- Reset asserted mid-operation: all buffered beats are discarded immediately (asynchronously). err_count clears.
- First accept is possible on the first rising edge after rst_n deasserts.
- Backpressure: a second beat arriving while the output is stalled fills the skid register, and in_ready drops on the following cycle.

## Configuration
- IMM_DECODE_RVC_EN defined: selects 6 and 7 become legal compressed formats.
  - 6 = CI: {inst[12], inst[6:2]}, sign-extended.
  - 7 = CJ: {inst[12], inst[8], inst[10:9], inst[6], inst[7], inst[2], inst[11], inst[5:3], 0}, sign-extended.
  - These selects never set out_err.
- Not defined: selects 6 and 7 are illegal, giving out_imm=0, out_err=1 and an err_count increment.

## Test plan
- Basic formats (XLEN=32, out_ready=1):
  - inst=0xFFF00093, sel=0 -> imm 0xFFFFFFFF one cycle later.
  - inst=0x123450B7, sel=3 -> 0x12345000.
  - inst=0x0010006F, sel=4 -> 0x00000800.
  - inst with [19:15]=5'h1F, sel=5 -> 0x0000001F.
- XLEN=64: inst=0x800000B7, sel=3 -> 0xFFFFFFFF80000000. Same inst with sel=5 -> 0x0000000000000000.
- Backpressure:
  - Stream tags 1,2,3,4 with out_ready=0 for 3 cycles -> in_ready low after the 2nd beat is accepted, out_tag holds 1.
  - On release, tags emerge 1,2,3,4 in order with no gaps after release.
- Illegal select, macro undefined: sel=6 -> out_imm=0, out_err=1, err_count=1. 300 such beats -> err_count=255.
- Macro defined: inst=0x10FD, sel=6 -> 0xFFFFFFFF with out_err=0.
- Reset with both storage entries full: out_valid=0 immediately on rst_n low. After release in_ready=1, err_count=0, and no stale beat emerges.
